// File: rtl/trig_pkg.sv
// Shared types and constants for trig_pipe: quarter-wave Q16 sine table,
// angle constants, quadrant encoding, S1 stage register and rounding helper.
package trig_pkg;

  localparam logic [8:0] DEG_90  = 9'd90;
  localparam logic [8:0] DEG_180 = 9'd180;
  localparam logic [8:0] DEG_270 = 9'd270;
  localparam logic [8:0] DEG_360 = 9'd360;

  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quad_e;

  typedef struct packed {
    quad_e      quad;
    logic [6:0] k;
  } stage_t;

  // round(sin(k deg) * 2^16), k = 0..90; entry 90 needs the 17th bit
  localparam logic [16:0] SIN_Q16 [0:90] = '{
    17'd0,     17'd1144,  17'd2287,  17'd3430,  17'd4572,  17'd5712,  17'd6850,
    17'd7987,  17'd9121,  17'd10252, 17'd11380, 17'd12505, 17'd13626, 17'd14742,
    17'd15855, 17'd16962, 17'd18064, 17'd19161, 17'd20252, 17'd21336, 17'd22415,
    17'd23486, 17'd24550, 17'd25607, 17'd26656, 17'd27697, 17'd28729, 17'd29753,
    17'd30767, 17'd31772, 17'd32768, 17'd33754, 17'd34729, 17'd35693, 17'd36647,
    17'd37590, 17'd38521, 17'd39441, 17'd40348, 17'd41243, 17'd42126, 17'd42995,
    17'd43852, 17'd44695, 17'd45525, 17'd46341, 17'd47143, 17'd47930, 17'd48703,
    17'd49461, 17'd50203, 17'd50931, 17'd51643, 17'd52339, 17'd53020, 17'd53684,
    17'd54332, 17'd54963, 17'd55578, 17'd56175, 17'd56756, 17'd57319, 17'd57865,
    17'd58393, 17'd58903, 17'd59396, 17'd59870, 17'd60326, 17'd60764, 17'd61183,
    17'd61584, 17'd61966, 17'd62328, 17'd62672, 17'd62997, 17'd63303, 17'd63589,
    17'd63856, 17'd64104, 17'd64332, 17'd64540, 17'd64729, 17'd64898, 17'd65048,
    17'd65177, 17'd65287, 17'd65376, 17'd65446, 17'd65496, 17'd65526, 17'd65536
  };

  // Round-half-up from Q16 to frac_w fractional bits; max entry cannot overflow 17 bits.
  function automatic logic [16:0] round_q16(input logic [16:0] e, input int frac_w);
    logic [16:0] half;
    if (frac_w >= 16) return e;
    half = 17'd1 << (15 - frac_w);
    return (e + half) >> (16 - frac_w);
  endfunction

endpackage

// File: rtl/sin_quarter_rom.sv
// Dual-read-port quarter-wave sine table with registered outputs (pipeline S2).
module sin_quarter_rom
  import trig_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic [6:0]  addr_a,
  input  logic [6:0]  addr_b,
  output logic [16:0] data_a,
  output logic [16:0] data_b
);

  // Addresses above 90 never occur from the fold; clamp keeps the read in range.
  function automatic logic [16:0] lookup(input logic [6:0] a);
    return (a > 7'd90) ? SIN_Q16[90] : SIN_Q16[a];
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_a <= '0;
      data_b <= '0;
    end else if (en) begin
      data_a <= lookup(addr_a);
      data_b <= lookup(addr_b);
    end
  end

endmodule

// File: rtl/trig_pipe.sv
// 3-stage sin/cos pipeline: S1 fold, S2 quarter-wave ROM, S3 sign/magnitude.
// Define TRIG_SIGNED_OUT_EN to add two's-complement outputs sin_s / cos_s.
module trig_pipe
  import trig_pkg::*;
#(
  parameter int FRAC_W = 12,
  parameter int TAG_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [8:0]        angle,
  input  logic [TAG_W-1:0]  tag_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FRAC_W:0]   sin_mag,
  output logic [FRAC_W:0]   cos_mag,
  output logic              sin_neg,
  output logic              cos_neg,
  output logic [TAG_W-1:0]  tag_out
`ifdef TRIG_SIGNED_OUT_EN
  ,
  output logic signed [FRAC_W+1:0] sin_s,
  output logic signed [FRAC_W+1:0] cos_s
`endif
);

  localparam int STAGES = 3;
  localparam int MW     = FRAC_W + 1;

  logic [STAGES:1]   vld_pipe;
  logic              advance;

  stage_t            s1_d, s1_q;
  logic [TAG_W-1:0]  tag1, tag2;
  quad_e             quad2;
  logic [8:0]        r;
  logic [16:0]       rom_sin, rom_cos;
  logic [FRAC_W:0]   mag_s, mag_c;
  logic              neg_s, neg_c;

  // The whole pipe moves unless a result is parked at the output.
  assign advance   = !(vld_pipe[STAGES] && !out_ready);
  assign in_ready  = advance;
  assign out_valid = vld_pipe[STAGES];

  // S1: reduce to 0..359 then fold into quadrant + first-quadrant index
  always_comb begin
    r         = (angle >= DEG_360) ? angle - DEG_360 : angle;
    s1_d.quad = QUAD_0;
    s1_d.k    = 7'(r);
    if (r > DEG_270) begin
      s1_d.quad = QUAD_3;
      s1_d.k    = 7'(DEG_360 - r);
    end else if (r > DEG_180) begin
      s1_d.quad = QUAD_2;
      s1_d.k    = 7'(r - DEG_180);
    end else if (r > DEG_90) begin
      s1_d.quad = QUAD_1;
      s1_d.k    = 7'(DEG_180 - r);
    end
  end

  sin_quarter_rom u_rom (
    .clock  (clock),
    .reset  (reset),
    .en     (advance),
    .addr_a (s1_q.k),
    .addr_b (7'd90 - s1_q.k),
    .data_a (rom_sin),
    .data_b (rom_cos)
  );

  // S3: rounding and sign; a zero magnitude never reports negative
  always_comb begin
    mag_s = MW'(round_q16(rom_sin, FRAC_W));
    mag_c = MW'(round_q16(rom_cos, FRAC_W));
    neg_s = (quad2 == QUAD_2 || quad2 == QUAD_3) && (mag_s != '0);
    neg_c = (quad2 == QUAD_1 || quad2 == QUAD_2) && (mag_c != '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      s1_q     <= '{quad: QUAD_0, k: '0};
      tag1     <= '0;
      quad2    <= QUAD_0;
      tag2     <= '0;
      sin_mag  <= '0;
      cos_mag  <= '0;
      sin_neg  <= 1'b0;
      cos_neg  <= 1'b0;
      tag_out  <= '0;
    end else if (advance) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      s1_q     <= s1_d;
      tag1     <= tag_in;
      quad2    <= s1_q.quad;
      tag2     <= tag1;
      sin_mag  <= mag_s;
      cos_mag  <= mag_c;
      sin_neg  <= neg_s;
      cos_neg  <= neg_c;
      tag_out  <= tag2;
    end
  end

`ifdef TRIG_SIGNED_OUT_EN
  assign sin_s = sin_neg ? -$signed({1'b0, sin_mag}) : $signed({1'b0, sin_mag});
  assign cos_s = cos_neg ? -$signed({1'b0, cos_mag}) : $signed({1'b0, cos_mag});
`endif

endmodule
